// File: rtl/rf_scrubber_pkg.sv
// Shared types and SEC-DED helpers for the register-file scrubber.
// Codeword layout: bit 0 is overall parity; bits 1..38 are Hamming positions,
// with check bits at the power-of-two positions and data bits filling the rest
// in ascending order.
package p_scrub;

    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 7;
    localparam int unsigned CWW   = DW + CW;
    localparam int unsigned HPOS  = CWW - 1;
    localparam int unsigned HBITS = CW - 1;

    typedef logic [CWW-1:0] codeword_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE
    } scrub_state_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v & (v - 1)) == 0;
    endfunction

    function automatic codeword_t secded_encode(input logic [DW-1:0] data);
        codeword_t   cw;
        int unsigned di;
        logic        par;
        cw = '0;
        di = 0;
        for (int unsigned pos = 1; pos <= HPOS; pos++) begin
            if (!is_pow2(pos)) begin
                cw[6'(pos)] = data[5'(di)];
                di++;
            end
        end
        for (int unsigned k = 0; k < HBITS; k++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos <= HPOS; pos++) begin
                if (((pos >> k) & 1) != 0) par ^= cw[6'(pos)];
            end
            cw[6'(1 << k)] = par;
        end
        cw[0] = ^cw[HPOS:1];
        return cw;
    endfunction

    // Low HBITS bits: Hamming syndrome (error position); top bit: overall parity.
    function automatic logic [CW-1:0] secded_syndrome(input codeword_t cw);
        logic [CW-1:0] s;
        s = '0;
        for (int unsigned k = 0; k < HBITS; k++) begin
            for (int unsigned pos = 1; pos <= HPOS; pos++) begin
                if (((pos >> k) & 1) != 0) s[3'(k)] ^= cw[6'(pos)];
            end
        end
        s[CW-1] = ^cw;
        return s;
    endfunction

endpackage

// File: rtl/rf_scrubber_secded_dec.sv
// Combinational SEC-DED decoder: corrects one flipped bit, flags two.
module secded_dec
    import p_scrub::*;
(
    input  codeword_t cw_i,
    output codeword_t cw_o,
    output logic      sec_o,
    output logic      ded_o
);

    logic [CW-1:0]    syn;
    logic [HBITS-1:0] pos;
    logic             par;
    logic             sec;

    // Classify the syndrome and flip the faulty bit on a correctable error.
    always_comb begin
        syn   = secded_syndrome(cw_i);
        pos   = syn[HBITS-1:0];
        par   = syn[CW-1];
        // Odd parity with a position past the codeword cannot be a single flip.
        sec   = par && (32'(pos) <= HPOS);
        sec_o = sec;
        ded_o = (!par && (pos != '0)) || (par && (32'(pos) > HPOS));
        cw_o  = cw_i;
        for (int unsigned i = 0; i < CWW; i++) begin
            if (sec && (32'(pos) == i)) cw_o[6'(i)] = ~cw_i[6'(i)];
        end
    end

endmodule

// File: rtl/rf_scrubber.sv
// Background scrubber and write-port arbiter for the SEC-DED register file.
// Walks the registers one step every PERIOD enabled idle cycles, rewrites
// single-bit errors, and always yields the RF write port to the core.
module rf_scrubber
    import p_scrub::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned CW         = 7,
    parameter int unsigned N          = 32,
    parameter int unsigned ADDW       = $clog2(N),
    parameter int unsigned PERIOD     = 256,
    parameter int unsigned START_ADDR = 1
) (
    input  logic               s_clk_i,
    input  logic               s_rst_i,
    input  logic               s_en_i,
    input  logic               s_core_we_i,
    input  logic [ADDW-1:0]    s_core_wadd_i,
    input  logic [DW+CW-1:0]   s_core_val_i,
    output logic [ADDW-1:0]    s_scrub_radd_o,
    input  logic [DW+CW-1:0]   s_scrub_rval_i,
    output logic               s_rf_we_o,
    output logic [ADDW-1:0]    s_rf_wadd_o,
    output logic [DW+CW-1:0]   s_rf_val_o,
    output logic               s_corr_o,
    output logic               s_uncorr_o,
    output logic [ADDW-1:0]    s_err_add_o,
    output logic [15:0]        s_corr_cnt_o,
    output logic               s_busy_o
);

    localparam int unsigned     CNTW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNTW-1:0] CNT_RELOAD = CNTW'(PERIOD - 1);
    localparam logic [ADDW-1:0] ADDR_FIRST = ADDW'(START_ADDR);
    localparam logic [ADDW-1:0] ADDR_LAST  = ADDW'(N - 1);

    scrub_state_t    state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [ADDW-1:0] addr_q, addr_d;
    codeword_t       chk_q, chk_d;
    codeword_t       fix_q, fix_d;
    logic            corr_q, corr_d;
    logic            uncorr_q, uncorr_d;
    logic [ADDW-1:0] err_add_q, err_add_d;
    logic [15:0]     corr_cnt_q, corr_cnt_d;

    codeword_t       dec_word;
    logic            dec_sec;
    logic            dec_ded;
    logic            hazard;
    logic            scrub_we;
    logic [ADDW-1:0] addr_next;

    secded_dec u_dec (
        .cw_i  (chk_q),
        .cw_o  (dec_word),
        .sec_o (dec_sec),
        .ded_o (dec_ded)
    );

    // Core collision on the register being scrubbed, and the wrapped next address.
    always_comb begin
        hazard    = s_core_we_i && (s_core_wadd_i == addr_q) && (state_q != S_IDLE);
        addr_next = (addr_q == ADDR_LAST) ? ADDR_FIRST : addr_q + ADDW'(1);
    end

    // Scrub FSM next-state, datapath and error reporting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        chk_d      = chk_q;
        fix_d      = fix_q;
        corr_d     = 1'b0;
        uncorr_d   = 1'b0;
        err_add_d  = err_add_q;
        corr_cnt_d = corr_cnt_q;
        scrub_we   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (s_en_i) begin
                    if (cnt_q == '0) begin
                        state_d = S_READ;
                        cnt_d   = CNT_RELOAD;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
            end
            S_READ: begin
                if (!s_en_i) begin
                    state_d = S_IDLE;
                end else if (hazard) begin
                    state_d = S_IDLE;
                    addr_d  = addr_next;
                end else begin
                    chk_d   = s_scrub_rval_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!s_en_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (dec_sec) begin
                        fix_d     = dec_word;
                        corr_d    = 1'b1;
                        err_add_d = addr_q;
                        if (corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
                        state_d   = S_WRITE;
                    end else begin
                        if (dec_ded) begin
                            uncorr_d  = 1'b1;
                            err_add_d = addr_q;
                        end
                        state_d = S_IDLE;
                        addr_d  = addr_next;
                    end
                    // The error is still reported, but the core's word supersedes any repair.
                    if (hazard) begin
                        fix_d   = '0;
                        state_d = S_IDLE;
                        addr_d  = addr_next;
                    end
                end
            end
            S_WRITE: begin
                if (!s_en_i) begin
                    state_d = S_IDLE;
                end else if (hazard) begin
                    fix_d   = '0;
                    state_d = S_IDLE;
                    addr_d  = addr_next;
                end else if (!s_core_we_i) begin
                    scrub_we = 1'b1;
                    state_d  = S_IDLE;
                    addr_d   = addr_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any pending write-back.
    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_RELOAD;
            addr_q     <= ADDR_FIRST;
            chk_q      <= '0;
            fix_q      <= '0;
            corr_q     <= 1'b0;
            uncorr_q   <= 1'b0;
            err_add_q  <= '0;
            corr_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            chk_q      <= chk_d;
            fix_q      <= fix_d;
            corr_q     <= corr_d;
            uncorr_q   <= uncorr_d;
            err_add_q  <= err_add_d;
            corr_cnt_q <= corr_cnt_d;
        end
    end

    // RF write-port mux: the core always wins, the scrubber fills idle cycles.
    always_comb begin
        s_rf_we_o   = s_core_we_i | scrub_we;
        s_rf_wadd_o = s_core_we_i ? s_core_wadd_i : addr_q;
        s_rf_val_o  = s_core_we_i ? s_core_val_i  : fix_q;
    end

    assign s_scrub_radd_o = addr_q;
    assign s_corr_o       = corr_q;
    assign s_uncorr_o     = uncorr_q;
    assign s_err_add_o    = err_add_q;
    assign s_corr_cnt_o   = corr_cnt_q;
    assign s_busy_o       = (state_q != S_IDLE);

endmodule
